instr_stream_exec: RTL and testbench

- Consumer end of the instruction-ROM stream: accepts 8-bit instruction bytes through a valid/ready handshake and executes them on an 8-bit accumulator datapath.
- Sits directly downstream of the instruction ROM sequencer. Its instr_in/instr_valid are driven from the ROM's instruction output, and stream_done from the ROM's done.
- Reports results through a one-cycle output strobe, plus halt, completion and illegal-state status.

---
 rtl/instr_stream_exec.sv | 142 ++++++++++++++
 tb/tb_instr_stream_exec.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_stream_exec.sv
`default_nettype none
// ============================================================================
//  Module      : instr_stream_exec
//  Description : Consumer end of the instruction-ROM stream. Accepts 8-bit
//                instructions over valid/ready and executes them on an 8-bit
//                accumulator. One instruction every two cycles
//                (FETCH then EXEC).
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_stream_exec #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       instr_in,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic             stream_done,
  output logic [7:0]       acc_out,
  output logic             carry,
  output logic [7:0]       out_data,
  output logic             out_valid,
  output logic             halted,
  output logic             finished,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_HALT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [2:0] c_OP_NOP  = 3'b000;
  localparam logic [2:0] c_OP_LDI  = 3'b001;
  localparam logic [2:0] c_OP_ADDI = 3'b010;
  localparam logic [2:0] c_OP_SUBI = 3'b011;
  localparam logic [2:0] c_OP_SHL  = 3'b100;
  localparam logic [2:0] c_OP_XORI = 3'b101;
  localparam logic [2:0] c_OP_OUT  = 3'b110;
  localparam logic [2:0] c_OP_HALT = 3'b111;

  state_t           state_q, state_d;
  logic [7:0]       ir_q, ir_d;
  logic [7:0]       acc_q, acc_d;
  logic             carry_q, carry_d;
  logic [7:0]       out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             halted_q, halted_d;
  logic             finished_q, finished_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // The 9-bit sum/difference carry out the carry and the borrow in bit 8.
  logic [7:0] imm_ext;
  logic [8:0] sum9;
  logic [8:0] diff9;

  assign imm_ext = {3'b000, ir_q[4:0]};
  assign sum9    = {1'b0, acc_q} + {1'b0, imm_ext};
  assign diff9   = {1'b0, acc_q} - {1'b0, imm_ext};

  // Next-state and datapath decode; strobes default low so they last one cycle.
  always_comb begin
    state_d     = state_q;
    ir_d        = ir_q;
    acc_d       = acc_q;
    carry_d     = carry_q;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;
    halted_d    = halted_q;
    finished_d  = 1'b0;
    cnt_d       = cnt_q;
    unique case (state_q)
      S_FETCH: begin
        // A pending instruction takes priority over end-of-stream.
        if (instr_valid) begin
          ir_d    = instr_in;
          state_d = S_EXEC;
        end else if (stream_done) begin
          finished_d = 1'b1;
          state_d    = S_DONE;
        end
      end
      S_EXEC: begin
        state_d = S_FETCH;
        cnt_d   = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
        unique case (ir_q[7:5])
          c_OP_NOP:  ;
          c_OP_LDI:  begin acc_d = imm_ext; carry_d = 1'b0; end
          c_OP_ADDI: begin acc_d = sum9[7:0]; carry_d = sum9[8]; end
          c_OP_SUBI: begin acc_d = diff9[7:0]; carry_d = diff9[8]; end
          c_OP_SHL:  begin acc_d = {acc_q[6:0], 1'b0}; carry_d = acc_q[7]; end
          c_OP_XORI: acc_d = acc_q ^ imm_ext;
          c_OP_OUT:  begin out_data_d = acc_q; out_valid_d = 1'b1; end
          c_OP_HALT: begin halted_d = 1'b1; state_d = S_HALT; end
          default:   ;
        endcase
      end
      // HALT and DONE are terminal: everything holds until reset.
      S_HALT:  ;
      S_DONE:  ;
      default: state_d = S_FETCH;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_FETCH;
      ir_q        <= 8'h00;
      acc_q       <= 8'h00;
      carry_q     <= 1'b0;
      out_data_q  <= 8'h00;
      out_valid_q <= 1'b0;
      halted_q    <= 1'b0;
      finished_q  <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      ir_q        <= ir_d;
      acc_q       <= acc_d;
      carry_q     <= carry_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      halted_q    <= halted_d;
      finished_q  <= finished_d;
      cnt_q       <= cnt_d;
    end
  end

  assign instr_ready = (state_q == S_FETCH);
  assign acc_out     = acc_q;
  assign carry       = carry_q;
  assign out_data    = out_data_q;
  assign out_valid   = out_valid_q;
  assign halted      = halted_q;
  assign finished    = finished_q;
  assign instr_count = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_stream_exec.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_stream_exec
//  Description : Self-checking bench for instr_stream_exec: table vectors,
//                hand-written corner sequences and randomized instructions
//                against a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_stream_exec;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] instr_in = 8'h00;
  logic       instr_valid = 1'b0;
  logic       instr_ready;
  logic       stream_done = 1'b0;
  logic [7:0] acc_out;
  logic       carry;
  logic [7:0] out_data;
  logic       out_valid;
  logic       halted;
  logic       finished;
  logic [7:0] instr_count;

  instr_stream_exec #(.CNT_W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .instr_in    (instr_in),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .stream_done (stream_done),
    .acc_out     (acc_out),
    .carry       (carry),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .halted      (halted),
    .finished    (finished),
    .instr_count (instr_count)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Behavioural model state (plain integers).
  int m_acc, m_carry, m_ov, m_od, m_halted, m_count;

  typedef struct {
    bit         rst_before;
    logic [7:0] instr;
    int         acc;
    int         cy;
    int         ov;
    int         od;
    int         hlt;
    int         cnt;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_acc = 0; m_carry = 0; m_ov = 0; m_od = 0; m_halted = 0; m_count = 0;
  endtask

  // Instruction semantics from the opcode table, in integer arithmetic.
  task automatic model_exec(input logic [7:0] ins);
    int op, imm;
    op  = int'(ins[7:5]);
    imm = int'(ins[4:0]);
    m_ov = 0;
    case (op)
      1: begin m_acc = imm; m_carry = 0; end
      2: begin m_carry = (m_acc + imm > 255) ? 1 : 0; m_acc = (m_acc + imm) % 256; end
      3: begin m_carry = (m_acc < imm) ? 1 : 0; m_acc = (m_acc - imm + 256) % 256; end
      4: begin m_carry = (m_acc >= 128) ? 1 : 0; m_acc = (m_acc * 2) % 256; end
      5: m_acc = m_acc ^ imm;
      6: begin m_od = m_acc; m_ov = 1; end
      7: m_halted = 1;
      default: ;
    endcase
    m_count = (m_count < 255) ? m_count + 1 : 255;
  endtask

  // Called at a negedge; leaves at a negedge with reset released.
  task automatic do_reset();
    rst = 1'b1; instr_valid = 1'b0; stream_done = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    check("rst_acc", acc_out, 0);
    check("rst_carry", carry, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_halted", halted, 0);
    check("rst_finished", finished, 0);
    check("rst_count", instr_count, 0);
    check("rst_ready", instr_ready, 1);
  endtask

  // Handshake one instruction and let it execute; called and returns at a negedge.
  task automatic drive_instr(input logic [7:0] b);
    int waited;
    waited = 0;
    instr_in = b; instr_valid = 1'b1;
    while (!instr_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!instr_ready) begin
      check("handshake_timeout", 0, 1);
      instr_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    check("exec_ready_low", instr_ready, 0);
    check("exec_out_valid_low", out_valid, 0);
    check("exec_finished_low", finished, 0);
    model_exec(b);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_model(input string tag);
    check({tag, "_acc"}, acc_out, m_acc);
    check({tag, "_carry"}, carry, m_carry);
    check({tag, "_out_valid"}, out_valid, m_ov);
    check({tag, "_out_data"}, out_data, m_od);
    check({tag, "_halted"}, halted, m_halted);
    check({tag, "_count"}, instr_count, m_count);
    check({tag, "_ready"}, instr_ready, m_halted ? 0 : 1);
    check({tag, "_finished"}, finished, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //               rst   instr  acc    cy ov od     hlt cnt
    vecs[0]  = '{1'b1, 8'h25, 'h05, 0, 0, 'h00, 0, 1};
    vecs[1]  = '{1'b0, 8'h43, 'h08, 0, 0, 'h00, 0, 2};
    vecs[2]  = '{1'b0, 8'hC0, 'h08, 0, 1, 'h08, 0, 3};
    vecs[3]  = '{1'b0, 8'hE0, 'h08, 0, 0, 'h08, 1, 4};
    vecs[4]  = '{1'b1, 8'h3F, 'h1F, 0, 0, 'h00, 0, 1};
    vecs[5]  = '{1'b0, 8'h80, 'h3E, 0, 0, 'h00, 0, 2};
    vecs[6]  = '{1'b0, 8'h80, 'h7C, 0, 0, 'h00, 0, 3};
    vecs[7]  = '{1'b0, 8'h80, 'hF8, 0, 0, 'h00, 0, 4};
    vecs[8]  = '{1'b0, 8'h5F, 'h17, 1, 0, 'h00, 0, 5};
    vecs[9]  = '{1'b0, 8'h7F, 'hF8, 1, 0, 'h00, 0, 6};
    vecs[10] = '{1'b0, 8'hBF, 'hE7, 1, 0, 'h00, 0, 7};
    vecs[11] = '{1'b0, 8'h00, 'hE7, 1, 0, 'h00, 0, 8};
    vecs[12] = '{1'b0, 8'hC0, 'hE7, 1, 1, 'hE7, 0, 9};
    vecs[13] = '{1'b0, 8'h20, 'h00, 0, 0, 'hE7, 0, 10};
    vecs[14] = '{1'b0, 8'h61, 'hFF, 1, 0, 'hE7, 0, 11};
    vecs[15] = '{1'b0, 8'h80, 'hFE, 1, 0, 'hE7, 0, 12};

    model_reset();
    repeat (2) @(negedge clk);

    // ---------------- Table vectors ----------------
    for (int i = 0; i < 16; i++) begin
      if (vecs[i].rst_before) do_reset();
      drive_instr(vecs[i].instr);
      check("tbl_acc", acc_out, vecs[i].acc);
      check("tbl_carry", carry, vecs[i].cy);
      check("tbl_out_valid", out_valid, vecs[i].ov);
      check("tbl_out_data", out_data, vecs[i].od);
      check("tbl_halted", halted, vecs[i].hlt);
      check("tbl_count", instr_count, vecs[i].cnt);
      check("tbl_ready", instr_ready, vecs[i].hlt ? 0 : 1);
    end

    // ---------------- HALT freezes everything ----------------
    do_reset();
    drive_instr(8'h29);
    drive_instr(8'hE0);
    instr_in = 8'h3F; instr_valid = 1'b1; stream_done = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("halt_ready", instr_ready, 0);
      check("halt_acc", acc_out, 'h09);
      check("halt_count", instr_count, 2);
      check("halt_flag", halted, 1);
      check("halt_finished", finished, 0);
    end
    instr_valid = 1'b0; stream_done = 1'b0;

    // ---------------- stream_done alone -> DONE ----------------
    do_reset();
    drive_instr(8'h23);
    stream_done = 1'b1;
    check("done_pre_ready", instr_ready, 1);
    @(posedge clk);
    @(negedge clk);
    check("done_finished_pulse", finished, 1);
    check("done_ready_low", instr_ready, 0);
    check("done_no_out_valid", out_valid, 0);
    instr_in = 8'h25; instr_valid = 1'b1;
    @(negedge clk);
    check("done_finished_once", finished, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("done_acc_frozen", acc_out, 'h03);
      check("done_ready_frozen", instr_ready, 0);
      check("done_count_frozen", instr_count, 1);
      check("done_finished_low", finished, 0);
    end
    instr_valid = 1'b0; stream_done = 1'b0;

    // ---------------- valid and stream_done together ----------------
    do_reset();
    instr_in = 8'h2A; instr_valid = 1'b1; stream_done = 1'b1;
    check("both_ready", instr_ready, 1);
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    check("both_exec_finished", finished, 0);
    check("both_exec_ready", instr_ready, 0);
    @(posedge clk);
    @(negedge clk);
    check("both_acc", acc_out, 'h0A);
    check("both_fetch_finished", finished, 0);
    check("both_fetch_ready", instr_ready, 1);
    @(posedge clk);
    @(negedge clk);
    check("both_finished_pulse", finished, 1);
    check("both_done_ready", instr_ready, 0);
    @(negedge clk);
    check("both_finished_end", finished, 0);
    stream_done = 1'b0;

    // ---------------- reset during EXEC ----------------
    do_reset();
    drive_instr(8'h25);
    instr_in = 8'h43; instr_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    check("rexec_in_exec", instr_ready, 0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    check("rexec_acc", acc_out, 0);
    check("rexec_carry", carry, 0);
    check("rexec_count", instr_count, 0);
    check("rexec_ready", instr_ready, 1);
    repeat (3) begin
      @(negedge clk);
      check("rexec_acc_stays", acc_out, 0);
    end

    // ---------------- counter saturation ----------------
    do_reset();
    for (int i = 0; i < 260; i++) begin
      drive_instr(8'h00);
      check("sat_ready_back", instr_ready, 1);
    end
    check("sat_count", instr_count, 255);

    // ---------------- randomized vs model ----------------
    do_reset();
    for (int i = 0; i < 300; i++) begin
      logic [7:0] b;
      int gap;
      b = {3'($urandom_range(0, 6)), 5'($urandom)};
      drive_instr(b);
      check_model("rnd");
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        m_ov = 0;
        check("rnd_idle_out_valid", out_valid, 0);
        check("rnd_idle_acc", acc_out, m_acc);
        check("rnd_idle_ready", instr_ready, 1);
      end
    end
    drive_instr(8'hE0);
    check_model("rnd_halt");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
